// File: rtl/sd_dat_rx.sv
// sd_dat_rx
//   Receives one 512-byte SD data block on the 4-bit DAT bus and writes it
//   byte-by-byte into the write port of a 512x8 sector buffer. It detects the
//   start bit, assembles nibbles into bytes, runs one CRC16-CCITT per DAT line,
//   checks the end bit and reports completion with status.
//
// Ports
//   clk        system clock, the only clock
//   resetn     synchronous active-low reset
//   start      one-cycle request to receive a block, honoured only when idle
//   sd_strobe  one-cycle enable marking the SD clock rising edge
//   sd_dat     SD DAT[3:0], already synchronised to clk
//   buf_addr   sector buffer byte address
//   buf_data   sector buffer write data
//   buf_wr     sector buffer write enable, one pulse per byte
//   busy       high from accepted start until done
//   done       one-cycle pulse at the end of a transfer (including timeout)
//   crc_ok     last transfer had good CRCs on all lines and a good end bit
//   timeout    last transfer gave up waiting for a start bit
module sd_dat_rx #(
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       sd_strobe,
  input  logic [3:0] sd_dat,
  output logic [8:0] buf_addr,
  output logic [7:0] buf_data,
  output logic       buf_wr,
  output logic       busy,
  output logic       done,
  output logic       crc_ok,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    DATA,
    CRC,
    END
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] tmo_cnt;
  logic [9:0]  nib_cnt;
  logic [3:0]  hi_nib;
  logic [15:0] crc_reg  [4];
  logic [15:0] crc_next [4];
  logic        crc_zero;

  // One step of CRC16-CCITT (x^16+x^12+x^5+1), MSB first, direct form.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // Each DAT line feeds its own CRC register. Once the transmitted CRC bits
  // have also been shifted through, a clean line leaves its register at zero.
  always_comb begin
    crc_zero = 1'b1;
    for (int n = 0; n < 4; n++) begin
      crc_next[n] = crc16_step(crc_reg[n], sd_dat[n]);
      if (crc_reg[n] != 16'h0000) begin
        crc_zero = 1'b0;
      end
    end
  end

  // State register; reset always returns to IDLE, abandoning any block.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Everything except the start request advances only on
  // an SD strobe; the nibble counter doubles as the CRC bit counter.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = WAIT_START;
        end
      end
      WAIT_START: begin
        if (sd_strobe) begin
          if (sd_dat == 4'b0000) begin
            next_state = DATA;
          end else if (tmo_cnt == TMO_LAST) begin
            next_state = IDLE;
          end
        end
      end
      DATA: begin
        if (sd_strobe && nib_cnt == 10'd1023) begin
          next_state = CRC;
        end
      end
      CRC: begin
        if (sd_strobe && nib_cnt == 10'd15) begin
          next_state = END;
        end
      end
      END: begin
        if (sd_strobe) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs. buf_wr and done are single-cycle pulses;
  // address and data are held between writes. An sd_strobe arriving in the
  // same cycle as an accepted start is deliberately ignored because IDLE does
  // not look at the strobe at all.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt  <= '0;
      nib_cnt  <= '0;
      hi_nib   <= '0;
      for (int n = 0; n < 4; n++) begin
        crc_reg[n] <= '0;
      end
      buf_addr <= '0;
      buf_data <= '0;
      buf_wr   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      buf_wr <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tmo_cnt <= '0;
            nib_cnt <= '0;
            for (int n = 0; n < 4; n++) begin
              crc_reg[n] <= '0;
            end
            crc_ok  <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b1;
          end
        end
        WAIT_START: begin
          if (sd_strobe && sd_dat != 4'b0000) begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_cnt == TMO_LAST) begin
              timeout <= 1'b1;
              crc_ok  <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        DATA: begin
          if (sd_strobe) begin
            nib_cnt <= nib_cnt + 10'd1;
            for (int n = 0; n < 4; n++) begin
              crc_reg[n] <= crc_next[n];
            end
            if (!nib_cnt[0]) begin
              hi_nib <= sd_dat;
            end else begin
              buf_data <= {hi_nib, sd_dat};
              buf_addr <= nib_cnt[9:1];
              buf_wr   <= 1'b1;
            end
          end
        end
        CRC: begin
          if (sd_strobe) begin
            for (int n = 0; n < 4; n++) begin
              crc_reg[n] <= crc_next[n];
            end
            nib_cnt <= (nib_cnt == 10'd15) ? 10'd0 : nib_cnt + 10'd1;
          end
        end
        END: begin
          if (sd_strobe) begin
            crc_ok <= crc_zero && (sd_dat == 4'b1111);
            done   <= 1'b1;
            busy   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_rx.sv
// tb_sd_dat_rx
//   Self-checking bench for sd_dat_rx. Blocks are generated from byte arrays;
//   the expected per-line CRCs come from a polynomial long-division model, and
//   the expected writes, their timing and the final status come from the
//   transmitted byte stream.
module tb_sd_dat_rx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       sd_strobe = 1'b0;
  logic [3:0] sd_dat = 4'hF;
  logic [8:0] buf_addr;
  logic [7:0] buf_data;
  logic       buf_wr;
  logic       busy;
  logic       done;
  logic       crc_ok;
  logic       timeout;

  typedef logic [7:0] block_t [512];

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     obs_addr[$];
  int     obs_data[$];
  int     obs_cyc[$];
  int     exp_cyc_q[$];
  int     done_count = 0;
  int     done_cyc = 0;
  logic   done_crc_ok = 1'b0;
  logic   done_tmo = 1'b0;
  logic   done_busy = 1'b0;
  block_t tx_bytes;

  sd_dat_rx #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .sd_strobe (sd_strobe),
    .sd_dat    (sd_dat),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .buf_wr    (buf_wr),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .timeout   (timeout)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Cycle counter plus an observer that samples outputs shortly after each
  // rising edge and logs every buffer write and every done pulse.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (buf_wr) begin
      obs_addr.push_back(int'(buf_addr));
      obs_data.push_back(int'(buf_data));
      obs_cyc.push_back(cyc);
    end
    if (done) begin
      done_count  = done_count + 1;
      done_cyc    = cyc;
      done_crc_ok = crc_ok;
      done_tmo    = timeout;
      done_busy   = busy;
    end
  end

  // Hard stop in case something hangs the run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Nibble k of a block in transmission order: high nibble of each byte first.
  function automatic logic [3:0] nibble_of(input block_t b, input int k);
    logic [7:0] byte_v;
    byte_v = b[k / 2];
    return (k % 2 == 1) ? byte_v[3:0] : byte_v[7:4];
  endfunction

  // CRC of one DAT line: remainder of (message * x^16) divided by 0x11021.
  function automatic logic [15:0] model_crc(input block_t b, input int line);
    logic [16:0] rem;
    logic [3:0]  nb;
    logic        bit_v;
    rem = '0;
    for (int k = 0; k < 1024 + 16; k++) begin
      bit_v = 1'b0;
      if (k < 1024) begin
        nb    = nibble_of(b, k);
        bit_v = nb[line];
      end
      rem = {rem[15:0], bit_v};
      if (rem[16]) begin
        rem = rem ^ 17'h11021;
      end
    end
    return rem[15:0];
  endfunction

  // Drives one strobe carrying a nibble, then idles until the next strobe
  // slot; between strobes the bus carries noise. Entered and left on negedge.
  task automatic applyStimulus(input logic [3:0] nib, input int period);
    sd_dat    = nib;
    sd_strobe = 1'b1;
    @(negedge clk);
    sd_strobe = 1'b0;
    start     = 1'b0;
    sd_dat    = 4'($urandom);
    repeat (period - 1) @(negedge clk);
  endtask

  // Issues a start request, optionally together with an all-zero strobe,
  // checks the freshly cleared status, then sends two non-start strobes.
  task automatic doStart(input bit coincide, input string tag);
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    exp_cyc_q.delete();
    start = 1'b1;
    if (coincide) begin
      sd_dat    = 4'b0000;
      sd_strobe = 1'b1;
    end
    @(negedge clk);
    start     = 1'b0;
    sd_strobe = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 1);
    checkOutput({tag, "_crc_ok_clr"}, 32'(crc_ok), 0);
    checkOutput({tag, "_timeout_clr"}, 32'(timeout), 0);
    applyStimulus(4'hF, 2);
    applyStimulus(4'b0010, 2);
  endtask

  // Compares logged writes with the expected byte stream and write timing.
  task automatic check_writes(input string tag, input block_t rx, input int n_exp);
    int f0;
    checkOutput({tag, "_wr_count"}, obs_addr.size(), n_exp);
    for (int k = 0; k < n_exp && k < obs_addr.size(); k++) begin
      f0 = failures;
      checkOutput({tag, "_wr_addr"}, obs_addr[k], k);
      checkOutput({tag, "_wr_data"}, obs_data[k], 32'(rx[k]));
      checkOutput({tag, "_wr_cycle"}, obs_cyc[k], exp_cyc_q[k]);
      if (failures != f0) break;
    end
  endtask

  // Sends a full block built from tx_bytes. Options: strobe period, a flipped
  // DAT2 bit at one nibble, a start pulse during DATA, the end-bit value, and
  // a reset after a given number of bytes.
  task automatic send_block(input string tag, input int period, input int flip_nib,
                            input int mid_start_nib, input logic [3:0] end_val,
                            input int abort_bytes);
    block_t      rx;
    logic [15:0] sent [4];
    logic [3:0]  nb;
    bit          exp_ok;
    int          c;
    int          done_before;
    int          n_wr;
    rx = tx_bytes;
    if (flip_nib >= 0) begin
      rx[flip_nib / 2] = rx[flip_nib / 2] ^ ((flip_nib % 2 == 0) ? 8'h40 : 8'h04);
    end
    exp_ok = (end_val == 4'hF);
    for (int n = 0; n < 4; n++) begin
      sent[n] = model_crc(tx_bytes, n);
      if (model_crc(rx, n) != sent[n]) exp_ok = 1'b0;
    end
    done_before = done_count;
    applyStimulus(4'h0, period);
    for (int i = 0; i < 1024; i++) begin
      nb = nibble_of(rx, i);
      if (i == mid_start_nib) start = 1'b1;
      c = cyc;
      applyStimulus(nb, period);
      if (i % 2 == 1) exp_cyc_q.push_back(c + 1);
      if (abort_bytes > 0 && i == 2 * abort_bytes - 1) begin
        check_writes({tag, "_pre"}, rx, abort_bytes);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_rst_addr"}, 32'(buf_addr), 0);
        checkOutput({tag, "_rst_data"}, 32'(buf_data), 0);
        checkOutput({tag, "_rst_wr"}, 32'(buf_wr), 0);
        checkOutput({tag, "_rst_busy"}, 32'(busy), 0);
        checkOutput({tag, "_rst_done"}, 32'(done), 0);
        checkOutput({tag, "_rst_crc_ok"}, 32'(crc_ok), 0);
        checkOutput({tag, "_rst_timeout"}, 32'(timeout), 0);
        resetn = 1'b1;
        n_wr   = obs_addr.size();
        repeat (40) applyStimulus(4'($urandom), 1);
        checkOutput({tag, "_no_wr_after"}, obs_addr.size(), n_wr);
        checkOutput({tag, "_no_done_after"}, done_count, done_before);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 0);
        return;
      end
    end
    for (int j = 0; j < 16; j++) begin
      for (int n = 0; n < 4; n++) begin
        nb[n] = sent[n][15 - j];
      end
      applyStimulus(nb, period);
    end
    c = cyc;
    applyStimulus(end_val, period);
    for (int t = 0; t < 20 && done_count == done_before; t++) @(negedge clk);
    check_writes(tag, rx, 512);
    checkOutput({tag, "_done_count"}, done_count - done_before, 1);
    checkOutput({tag, "_done_cycle"}, done_cyc, c + 1);
    checkOutput({tag, "_crc_ok"}, 32'(done_crc_ok), 32'(exp_ok));
    checkOutput({tag, "_timeout"}, 32'(done_tmo), 0);
    checkOutput({tag, "_busy_at_done"}, 32'(done_busy), 0);
  endtask

  // Test sequence.
  initial begin
    int c;
    int done_before;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_addr", 32'(buf_addr), 0);
    checkOutput("reset_data", 32'(buf_data), 0);
    checkOutput("reset_wr", 32'(buf_wr), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_crc_ok", 32'(crc_ok), 0);
    checkOutput("reset_timeout", 32'(timeout), 0);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] good block, strobe every 4th clk");
    for (int k = 0; k < 512; k++) tx_bytes[k] = 8'(k);
    doStart(1'b0, "good");
    send_block("good", 4, -1, -1, 4'hF, 0);

    $display("[TB] DAT2 flipped at nibble 37");
    for (int k = 0; k < 512; k++) tx_bytes[k] = 8'($urandom);
    doStart(1'b0, "flip");
    send_block("flip", 2, 37, -1, 4'hF, 0);

    $display("[TB] bad end bit, full-rate strobes");
    for (int k = 0; k < 512; k++) tx_bytes[k] = 8'($urandom);
    doStart(1'b0, "endbit");
    send_block("endbit", 1, -1, -1, 4'hE, 0);

    $display("[TB] start-bit timeout");
    doStart(1'b0, "tmo");
    done_before = done_count;
    c = 0;
    for (int s = 3; s <= 16; s++) begin
      if (s == 16) checkOutput("tmo_early_done", done_count - done_before, 0);
      c = cyc;
      applyStimulus((s == 5) ? 4'b0111 : 4'b1111, 2);
    end
    checkOutput("tmo_done_count", done_count - done_before, 1);
    checkOutput("tmo_done_cycle", done_cyc, c + 1);
    checkOutput("tmo_timeout", 32'(done_tmo), 1);
    checkOutput("tmo_crc_ok", 32'(done_crc_ok), 0);
    checkOutput("tmo_busy", 32'(done_busy), 0);
    checkOutput("tmo_writes", obs_addr.size(), 0);

    $display("[TB] reset after 100 bytes");
    for (int k = 0; k < 512; k++) tx_bytes[k] = 8'($urandom);
    doStart(1'b0, "abort");
    send_block("abort", 2, -1, -1, 4'hF, 100);

    $display("[TB] restart with coinciding strobe and mid-block start");
    for (int k = 0; k < 512; k++) tx_bytes[k] = 8'(k);
    doStart(1'b1, "restart");
    send_block("restart", 3, -1, 300, 4'hF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_dat_rx.md
# sd_dat_rx

Receives one 512-byte SD card data block on the 4-bit DAT bus and writes it byte-by-byte into the 512x8 sector buffer's write port. It sits between the SD command/clock controller, which issues the read command and generates the SD clock, and the sector buffer. The buffer's other port is drained by the floppy/ACSI side. The block detects the start bit, assembles nibbles into bytes, checks the four per-line CRC16s and the end bit, and reports completion with status.

## Interface
Parameters:
- TIMEOUT, default 65535: number of sample strobes to wait for a start bit before giving up; 1..65535.

Ports:
- clk  in  1  system clock; the only clock.
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to receive one block; honoured only in IDLE.
- sd_strobe  in  1  one-cycle enable marking the SD clock rising edge; sd_dat is sampled only in these cycles.
- sd_dat  in  4  SD DAT[3:0], already synchronised to clk.
- buf_addr  out  9  sector buffer byte address.
- buf_data  out  8  sector buffer write data.
- buf_wr  out  1  sector buffer write enable, one-cycle pulse per byte.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of transfer, including timeout.
- crc_ok  out  1  status of the last transfer; valid from done until the next accepted start.
- timeout  out  1  status of the last transfer; valid from done until the next accepted start.

## Operation
- States: IDLE, WAIT_START, DATA, CRC, END.
- IDLE:
  - start=1 → WAIT_START.
  - On entry to WAIT_START: clear the timeout counter, all four CRC registers, the nibble counter, crc_ok and timeout. Set busy.
  - An sd_strobe in the same cycle as start is not sampled.
- WAIT_START, on each strobe:
  - sd_dat==4'b0000 → DATA.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT → IDLE, with timeout=1, crc_ok=0, a done pulse, and busy cleared.
  - Any partial start bit (some lines low, others high) is not a start bit.
- DATA, 1024 strobes with a 10-bit nibble counter:
  - Even count: latch sd_dat as the high nibble. Odd count: low nibble.
  - After each odd count: buf_data={hi,lo}, buf_addr=count[9:1], buf_wr=1.
  - Each strobe shifts sd_dat[n] into CRC register n. CRC is CRC16-CCITT, x^16+x^12+x^5+1, init 0x0000, MSB first.
  - After count 1023 → CRC; the counter wraps to 0.
- CRC, 16 strobes:
  - The received CRC bits keep shifting through the same CRC registers.
  - After the 16th strobe, the line checks pass if all four registers are 0x0000.
  - → END.
- END, 1 strobe:
  - crc_ok = (all CRC registers zero) AND (sd_dat==4'b1111).
  - Pulse done, clear busy → IDLE.
- Bytes are written regardless of CRC outcome. The consumer must discard the buffer when crc_ok=0.
- start while busy is ignored; there is no queueing.
- resetn=0 in any state:
  - Next cycle: IDLE, with busy, done, buf_wr, crc_ok and timeout all 0, and buf_addr=0, buf_data=0.
  - Any partial block is abandoned, and no further writes occur.

## Timing
- All outputs are registered.
- Reset values: every output 0.
- buf_wr is asserted in the cycle after the strobe that delivered the low nibble. buf_addr and buf_data are valid in that same cycle and held until the next write.
- Byte k is written 1 clk after data strobe 2k+1.
- Between consecutive writes there is at least 1 clk, since strobes are at most every cycle.
- done and the final crc_ok/timeout values appear 1 clk after the END strobe, or 1 clk after the TIMEOUT-th WAIT_START strobe.
- busy falls in the same cycle done rises.
- sd_strobe held high every cycle is legal: full throughput is 1 nibble/clk.
- Minimum block duration from the start-bit strobe: 1 + 1024 + 16 + 1 strobes.

## Test plan
- Good block: byte i = i[7:0], with correct per-line CRCs from the bench model, strobe every 4th clk. Required: 512 writes at addr 0..511 with data 0x00..0xFF repeating; done once; crc_ok=1; timeout=0.
- Flip one data bit on DAT2 at nibble 37. Required: 512 writes still occur, with byte 18 corrupted; crc_ok=0.
- All CRCs correct but sd_dat=4'b1110 at the end bit. Required: crc_ok=0, done pulses.
- TIMEOUT=16, sd_dat held 4'b1111, and sd_dat=4'b0111 once. Required: done 1 clk after the 16th strobe, timeout=1, crc_ok=0, zero writes.
- resetn low for 1 clk after 100 data bytes. Required: all outputs 0 next cycle, no further buf_wr. A fresh start then receives a full good block with crc_ok=1.
- start pulsed mid-DATA, and start coinciding with a strobe carrying 4'b0000 in IDLE. Required: the mid-DATA start has no effect. The coinciding strobe is not taken as the start bit; reception begins on the next 4'b0000 strobe.
